// File: rtl/uart_axis_pkg.sv
// Shared types and constants for the UART receive AXI-Stream framer.
// Optional packet-length cap in the top level is enabled with `define UART_AXIS_MAXPKT_EN.
package uart_axis_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int OVF_W = 8;

  // A packet closes after two idle character times (start + 8 data + parity + stop).
  localparam int CHAR_BITS     = 11;
  localparam int CHARS_PER_GAP = 2;

  function automatic int idle_cycles_for(input int clk_freq, input int baud);
    return CHARS_PER_GAP * CHAR_BITS * (clk_freq / baud);
  endfunction

  localparam int DEFAULT_CLK_FREQ    = 50_000_000;
  localparam int DEFAULT_BAUD        = 115_200;
  localparam int DEFAULT_IDLE_CYCLES = idle_cycles_for(DEFAULT_CLK_FREQ, DEFAULT_BAUD);

endpackage

// File: rtl/rx_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is visible whenever not empty.
// Push while full is accepted only together with a pop, leaving the level unchanged.
module rx_fifo_fwft #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign level_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Gated so the stream data reads zero rather than stale storage when empty.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_axis_framer.sv
// Buffers UART receiver bytes and re-emits them as AXI-Stream, deriving tlast from line idle.
// `define UART_AXIS_MAXPKT_EN additionally closes a packet after MAX_PKT bytes.
module uart_rx_axis_framer
  import uart_axis_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
  parameter int MAX_PKT     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_valid,
  output logic [WIDTH-1:0]         m_axis_data,
  output logic                     m_axis_valid,
  input  logic                     m_axis_ready,
  output logic                     m_axis_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [OVF_W-1:0]         overflow_cnt,
  input  logic                     clr_stats
);

  localparam int              TW          = $clog2(IDLE_CYCLES + 1);
  localparam logic [TW-1:0]   TIMEOUT_VAL = TW'(IDLE_CYCLES - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_PKT < 1 || IDLE_CYCLES < 1) begin : g_bad_param
    $error("uart_rx_axis_framer: illegal parameter combination");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  stage_q, stage_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic              push, push_last, drop, load;
  logic              fifo_full, fifo_empty;
  logic [WIDTH:0]    fifo_head;

`ifdef UART_AXIS_MAXPKT_EN
  localparam int PW = $clog2(MAX_PKT + 1);
  logic [PW-1:0]     pkt_q, pkt_d;
`endif

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    timer_d   = timer_q;
    push      = 1'b0;
    push_last = 1'b0;
    drop      = 1'b0;
    load      = 1'b0;
`ifdef UART_AXIS_MAXPKT_EN
    pkt_d     = pkt_q;
`endif

    case (state_q)
      EMPTY: begin
        if (rx_valid) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A new byte beats a same-cycle timeout: the staged byte was not the last one.
        if (rx_valid) begin
          timer_d = '0;
          if (!fifo_full) begin
            push = 1'b1;
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (timer_q == TIMEOUT_VAL) begin
          if (!fifo_full) begin
            push      = 1'b1;
            push_last = 1'b1;
            state_d   = EMPTY;
          end else begin
            state_d   = FLUSH;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FLUSH: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_last = 1'b1;
          if (rx_valid) begin
            load    = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = EMPTY;
          end
        end else if (rx_valid) begin
          drop = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (load) begin
      stage_d = rx_data;
      timer_d = '0;
    end

`ifdef UART_AXIS_MAXPKT_EN
    // The byte that fills the packet is parked in FLUSH so it leaves as last without waiting.
    if (push && push_last) pkt_d = '0;
    if (load) begin
      pkt_d = pkt_d + PW'(1);
      if (pkt_d == PW'(MAX_PKT)) state_d = FLUSH;
    end
`endif

    if (clr_stats) begin
      ovf_d = '0;
    end else if (drop && ovf_q != '1) begin
      ovf_d = ovf_q + OVF_W'(1);
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      stage_q <= '0;
      timer_q <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef UART_AXIS_MAXPKT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_q <= '0;
    else        pkt_q <= pkt_d;
  end
`endif

  rx_fifo_fwft #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({push_last, stage_q}),
    .pop_i       (m_axis_ready),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .level_o     (fifo_level)
  );

  assign m_axis_valid = !fifo_empty;
  assign m_axis_last  = fifo_head[WIDTH];
  assign m_axis_data  = fifo_head[WIDTH-1:0];
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_uart_rx_axis_framer.sv
// Directed and randomized bench for uart_rx_axis_framer against a byte-gap packet model.
// Define UART_AXIS_MAXPKT_EN for both bench and RTL to exercise the packet-length cap.
module tb_uart_rx_axis_framer;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int IDLE    = 20;
  localparam int MAX_PKT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        m_axis_ready = 1'b1;
  logic        clr_stats = 1'b0;
  logic [7:0]  m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_last;
  logic [2:0]  fifo_level;
  logic [7:0]  overflow_cnt;

  uart_rx_axis_framer #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .IDLE_CYCLES (IDLE),
    .MAX_PKT     (MAX_PKT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt),
    .clr_stats    (clr_stats)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    beats = 0;
  int    last_beat_cyc = 0;

  // Packet model: a byte is last if IDLE quiet cycles follow it (or the byte cap is reached).
  bit         pend = 1'b0;
  logic [7:0] pend_data = '0;
  int         idle_run = 0;
  int         pkt_n = 0;
  bit         rand_ready = 1'b0;
  int         ready_low_run = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) begin
      if (ready_low_run >= 2 || $urandom_range(0, 2) != 0) begin
        m_axis_ready  = 1'b1;
        ready_low_run = 0;
      end else begin
        m_axis_ready  = 1'b0;
        ready_low_run++;
      end
    end
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b0;
      tick();
      idle_run++;
      if (pend && idle_run >= IDLE) begin
        exp_q.push_back({1'b1, pend_data});
        pend  = 1'b0;
        pkt_n = 0;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, output int rx_cyc);
    if (pend) exp_q.push_back({1'b0, pend_data});
    rx_data  = d;
    rx_valid = 1'b1;
    rx_cyc   = cyc;
    tick();
    rx_valid = 1'b0;
    idle_run = 0;
    pkt_n++;
`ifdef UART_AXIS_MAXPKT_EN
    if (pkt_n == MAX_PKT) begin
      exp_q.push_back({1'b1, d});
      pend  = 1'b0;
      pkt_n = 0;
    end else begin
      pend      = 1'b1;
      pend_data = d;
    end
`else
    pend      = 1'b1;
    pend_data = d;
`endif
  endtask

  task automatic raw_byte(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int limit);
    int target;
    target = beats + n;
    for (int i = 0; i < limit && beats < target; i++) tick();
    check(tag, beats, target);
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && m_axis_valid && m_axis_ready) begin
        beats++;
        last_beat_cyc = cyc;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=%0h expected=none", {m_axis_last, m_axis_data});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("beat %0d data=%02h last=%0d cyc=%0d", beats, m_axis_data, m_axis_last, cyc);
          check("beat", {23'd0, m_axis_last, m_axis_data}, {23'd0, e});
        end
      end
    end
  endtask

  initial begin
    int t;
    int t4;
    int b0;

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", m_axis_valid, 0);
    check("rst_last", m_axis_last, 0);
    check("rst_data", m_axis_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow_cnt, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", m_axis_valid, 0);

    // Three bytes, 10 cycles apart, then idle
    b0 = beats;
    send(8'h11, t); wait_idle(9);
    send(8'h22, t); wait_idle(9);
    send(8'h33, t); wait_idle(30);
    check("t1_beats", beats - b0, 3);
    check("t1_last_latency", last_beat_cyc - t, IDLE + 1);

    // Single byte
    b0 = beats;
    send(8'hA5, t); wait_idle(30);
    check("t2_beats", beats - b0, 1);
    check("t2_latency", last_beat_cyc - t, IDLE + 1);

    // Byte arriving on the exact timeout cycle of the staged one
    b0 = beats;
    send(8'h3C, t); wait_idle(IDLE - 1);
    send(8'h7E, t); wait_idle(IDLE - 2);
    check("t4_first_beat", beats - b0, 1);
    wait_idle(10);
    check("t4_beats", beats - b0, 2);
    check("t4_latency", last_beat_cyc - t, IDLE + 1);

    // Backpressure and overflow
    m_axis_ready = 1'b0;
    b0 = beats;
    for (int i = 1; i <= 6; i++) begin
      raw_byte(8'(i));
      repeat (4) tick();
    end
    repeat (IDLE + 5) tick();
    check("t3_level", fifo_level, 4);
    check("t3_ovf", overflow_cnt, 1);
    check("t3_valid", m_axis_valid, 1);
    check("t3_head", m_axis_data, 8'h01);
    for (int i = 0; i < 260; i++) raw_byte(8'hEE);
    check("t3_ovf_sat", overflow_cnt, 255);
    clr_stats = 1'b1;
    raw_byte(8'hEF);
    clr_stats = 1'b0;
    check("t3_clr_priority", overflow_cnt, 0);
    raw_byte(8'hF0);
    check("t3_ovf_after_clr", overflow_cnt, 1);
    check("t3_level_held", fifo_level, 4);
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b0, 8'h03});
`ifdef UART_AXIS_MAXPKT_EN
    exp_q.push_back({1'b1, 8'h04});
`else
    exp_q.push_back({1'b0, 8'h04});
`endif
    exp_q.push_back({1'b1, 8'h05});
    m_axis_ready = 1'b1;
    wait_beats("t3_drain", 5, 40);
    repeat (3) tick();
    check("t3_level_end", fifo_level, 0);

    // Reset with two bytes queued and one staged
    m_axis_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      raw_byte(8'hC0 + 8'(i));
      repeat (2) tick();
    end
    check("t5_level_before", fifo_level, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid_in_rst", m_axis_valid, 0);
    check("t5_level_in_rst", fifo_level, 0);
    tick();
    rst_n = 1'b1;
    m_axis_ready = 1'b1;
    b0 = beats;
    repeat (40) tick();
    check("t5_no_beats", beats - b0, 0);
    check("t5_ovf", overflow_cnt, 0);

    // Six bytes, 5 cycles apart
    b0 = beats;
    for (int i = 1; i <= 6; i++) begin
      send(8'h40 + 8'(i), t);
      if (i == 4) t4 = t;
      if (i == 4) begin
        wait_idle(4);
`ifdef UART_AXIS_MAXPKT_EN
        check("t6_cap_latency", last_beat_cyc - t4, 2);
        check("t6_cap_beats", beats - b0, 4);
`else
        check("t6_mid_beats", beats - b0, 3);
`endif
      end else begin
        wait_idle(4);
      end
    end
    wait_idle(IDLE + 5);
    check("t6_beats", beats - b0, 6);
    check("t6_tail_latency", last_beat_cyc - t, IDLE + 1);

    // Randomized gaps around the idle threshold with throttled ready
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       wait_idle(3 + $urandom_range(0, 4));
        1:       wait_idle(IDLE - 1);
        2:       wait_idle(IDLE);
        default: wait_idle(IDLE + 1 + $urandom_range(0, 2));
      endcase
      send(8'($urandom), t);
    end
    wait_idle(IDLE + 10);
    rand_ready   = 1'b0;
    m_axis_ready = 1'b1;
    repeat (10) tick();
    check("rand_drained", exp_q.size(), 0);
    check("rand_ovf", overflow_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
